folded_maj_sched: RTL and testbench

//  Sequential, folded evaluator for an N-input majority (bias) function. It shares one
//  W-bit popcount unit across ceil(N/W) chunks instead of building a full N-input tree.
//  It accepts one vector per valid/ready handshake, accumulates chunk counts one chunk
//  per cycle, exits early once the outcome is fixed, and returns y = (popcount >= THRESH).

---
 rtl/maj_pkg.sv | 28 ++
 rtl/maj_chunk_popcount.sv | 19 +
 rtl/folded_maj_sched.sv | 124 ++++++++++++
 tb/tb_folded_maj_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared types and sizing helpers for the folded majority scheduler.
package maj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Number of W-bit chunks needed to cover an N-bit vector.
    function automatic int nch(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    // Counter width able to hold 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits still unseen after chunk k has been folded in.
    function automatic int rem_after(input int n, input int w, input int k);
        int seen;
        seen = (k + 1) * w;
        if (seen > n) seen = n;
        return n - seen;
    endfunction

endpackage

// File: rtl/maj_chunk_popcount.sv
// Combinational W-bit popcount; the one counting unit shared by every chunk.
module maj_chunk_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int PW = $clog2(W + 1);

    // Sum the ones in the chunk.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/folded_maj_sched.sv
// Folded N-input majority: one shared W-bit popcount walks the chunks of a
// captured vector, stopping early once the outcome can no longer change.
module folded_maj_sched
    import maj_pkg::*;
#(
    parameter int N          = 39,
    parameter int W          = 8,
    parameter int THRESH     = (N + 1) / 2,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N-1:0]                    in_x,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_y,
    output logic [cnt_w(N)-1:0]             out_count,
    output logic [$clog2(nch(N,W)+1)-1:0]   out_chunks
);

    localparam int NCH = nch(N, W);
    localparam int CW  = cnt_w(N);
    localparam int PW  = $clog2(W + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OW  = $clog2(NCH + 1);

    state_t           state_q, state_d;
    logic [N-1:0]     shadow_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;

    logic [NCH*W-1:0] xpad;
    logic [W-1:0]     chunk;
    logic [PW-1:0]    pc;
    logic [CW-1:0]    cnt_n;
    int               reach;
    logic             decided;
    logic             accept;
    logic             finish;

    // Zero-extend the captured vector so the last chunk reads 0 past bit N-1.
    always_comb begin
        xpad          = '0;
        xpad[N-1:0]   = shadow_q;
        chunk         = xpad[int'(idx_q)*W +: W];
    end

    maj_chunk_popcount #(.W(W)) u_pop (
        .bits  (chunk),
        .count (pc)
    );

    // Running count and the decision test: threshold reached, or unreachable
    // even if every unseen bit were a one.
    always_comb begin
        cnt_n   = cnt_q + CW'(pc);
        reach   = int'(cnt_n) + rem_after(N, W, int'(idx_q));
        decided = (int'(idx_q) == NCH - 1) ||
                  (EARLY_EXIT && ((int'(cnt_n) >= THRESH) || (reach < THRESH)));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake control.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (decided) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow capture, accumulation and result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_y      <= 1'b0;
            out_count  <= '0;
            out_chunks <= '0;
        end else if (accept) begin
            shadow_q <= in_x;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else if (state_q == ST_ACCUM) begin
            if (finish) begin
                out_y      <= (int'(cnt_n) >= THRESH);
                out_count  <= cnt_n;
                out_chunks <= OW'(idx_q) + OW'(1);
            end else begin
                cnt_q <= cnt_n;
                idx_q <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_folded_maj_sched.sv
// Bench for folded_maj_sched: directed spec vectors, backpressure, mid-fold
// reset and a random sweep on an early-exit and a full-fold instance.
module tb_folded_maj_sched;

    logic        clk;
    logic        rst;
    logic [38:0] in_x;
    logic        iv   [2];
    logic        ordy [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        oy   [2];
    logic [5:0]  oc   [2];
    logic [2:0]  och  [2];

    int total;
    int bad;

    folded_maj_sched #(.N(39), .W(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_x(in_x),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_y(oy[0]),
        .out_count(oc[0]), .out_chunks(och[0])
    );

    folded_maj_sched #(.N(39), .W(8), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_x(in_x),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_y(oy[1]),
        .out_count(oc[1]), .out_chunks(och[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: fold the vector chunk by chunk, recounting every bit seen so
    // far from scratch; the result is the plain majority of all 39 bits.
    task automatic model(input logic [38:0] x, input bit ee,
                         output bit y, output int c, output int ch);
        int seen;
        int ones;
        ones = 0;
        for (int b = 0; b < 39; b++) ones += int'(x[b]);
        y  = (ones >= 20);
        c  = 0;
        ch = 0;
        for (int k = 0; k < 5; k++) begin
            seen = (k + 1) * 8;
            if (seen > 39) seen = 39;
            c = 0;
            for (int b = 0; b < seen; b++) c += int'(x[b]);
            ch = k + 1;
            if (ee && ((c >= 20) || (c + (39 - seen) < 20))) break;
        end
    endtask

    // One full transaction on instance sel, holding out_ready low for 'hold'
    // cycles in DONE and checking the outputs stay put.
    task automatic run_vec(input int sel, input logic [38:0] x, input int hold,
                           input string tag, input bit ey, input int ec, input int ech);
        int lat;
        chk({tag, ".in_ready_pre"}, 64'(ir[sel]), 64'd1);
        in_x     = x;
        iv[sel]  = 1'b1;
        @(posedge clk); #1;
        iv[sel]  = 1'b0;
        in_x     = ~x;
        lat = 0;
        while (!ov[sel] && lat < 20) begin
            chk({tag, ".in_ready_busy"}, 64'(ir[sel]), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(ech));
        chk({tag, ".y"},       64'(oy[sel]),  64'(ey));
        chk({tag, ".count"},   64'(oc[sel]),  64'(ec));
        chk({tag, ".chunks"},  64'(och[sel]), 64'(ech));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'(ov[sel]),  64'd1);
            chk({tag, ".hold_ready"}, 64'(ir[sel]),  64'd0);
            chk({tag, ".hold_y"},     64'(oy[sel]),  64'(ey));
            chk({tag, ".hold_count"}, 64'(oc[sel]),  64'(ec));
            chk({tag, ".hold_chunks"},64'(och[sel]), 64'(ech));
        end
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        chk({tag, ".valid_drop"}, 64'(ov[sel]), 64'd0);
        chk({tag, ".ready_back"}, 64'(ir[sel]), 64'd1);
    endtask

    task automatic run_model(input int sel, input logic [38:0] x, input string tag);
        bit y; int c; int ch;
        model(x, (sel == 0), y, c, ch);
        run_vec(sel, x, 0, tag, y, c, ch);
        if (sel == 1) chk({tag, ".full_chunks"}, 64'(och[1]), 64'd5);
    endtask

    initial begin
        logic [38:0] rx;
        logic [38:0] ra;
        logic [38:0] rb;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        in_x    = '0;
        iv[0]   = 1'b0; iv[1]   = 1'b0;
        ordy[0] = 1'b0; ordy[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            chk("rst.in_ready",  64'(ir[s]),  64'd1);
            chk("rst.out_valid", 64'(ov[s]),  64'd0);
            chk("rst.out_y",     64'(oy[s]),  64'd0);
            chk("rst.out_count", 64'(oc[s]),  64'd0);
            chk("rst.out_chunks",64'(och[s]), 64'd0);
        end

        // Directed vectors on the early-exit instance.
        run_vec(0, {39{1'b1}},       0, "ones",  1'b1, 24, 3);
        run_vec(0, 39'h0,            0, "zero",  1'b0, 0,  3);
        run_vec(0, 39'h00000FFFFF,   0, "low20", 1'b1, 20, 3);
        run_vec(0, 39'h7FFFF00000,   0, "hi19",  1'b0, 4,  3);
        run_vec(0, 39'h5555555555,   0, "even",  1'b1, 20, 5);
        // Full-fold instance on the same patterns.
        run_vec(1, {39{1'b1}},       0, "f_ones", 1'b1, 39, 5);
        run_vec(1, 39'h0,            0, "f_zero", 1'b0, 0,  5);
        run_vec(1, 39'h7FFFF00000,   0, "f_hi19", 1'b0, 19, 5);

        // Backpressure in DONE.
        run_vec(0, {39{1'b1}},       3, "bp",    1'b1, 24, 3);

        // Reset during the second ACCUM cycle discards the vector.
        in_x  = {39{1'b1}};
        iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        chk("mid.busy", 64'(ir[1]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid.in_ready",  64'(ir[1]), 64'd1);
        chk("mid.out_valid", 64'(ov[1]), 64'd0);
        chk("mid.out_count", 64'(oc[1]), 64'd0);
        @(posedge clk); #1;
        chk("mid.stay_idle", 64'(ov[1]), 64'd0);
        run_vec(1, 39'h5555555555, 0, "mid.recover", 1'b1, 20, 5);

        // Random sweep; density varied so results land near the threshold.
        for (int i = 0; i < 60; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       rx = ra & rb;
                1:       rx = ra | rb;
                default: rx = ra;
            endcase
            run_model(i % 2, rx, (i % 2 == 0) ? "rnd_ee" : "rnd_full");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
